// File: rtl/lbp_pkg.sv
// ============================================================================
// Module   : lbp_pkg
// Brief    : Shared image geometry and FSM encoding for the LBP host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbp_pkg;

    localparam int IMG_W     = 128;
    localparam int MEM_DEPTH = 16384;
    localparam int ADDR_W    = 14;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } lbp_state_t;

endpackage

`default_nettype wire

// File: rtl/lbp_img_ram.sv
// ============================================================================
// Module   : lbp_img_ram
// Brief    : Image RAM with one sync write, one async read, one registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_img_ram
    import lbp_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int WIDTH  = 8,
    parameter int AW     = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    araddr,
    output logic [WIDTH-1:0] ardata,
    input  logic [AW-1:0]    rraddr,
    output logic [WIDTH-1:0] rrdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array is deliberately not reset so contents survive a host reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Non-blocking read returns the pre-write word on a same-cycle collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[rraddr];
        end
    end

    assign ardata = r_mem[araddr];
    assign rrdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/lbp_host.sv
// ============================================================================
// Module   : lbp_host
// Brief    : Gray image loader and LBP result collector for an LBP engine.
//            Optional duplicate-write checker enabled by LBP_HOST_DUPCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_host
    import lbp_pkg::*;
#(
    parameter int MEM_DEPTH = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic              gray_ready,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              done,
    output logic [14:0]       wr_count,
    output logic              dup_err
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [14:0]       c_wr_max    = 15'(MEM_DEPTH);

    lbp_state_t        r_state;
    logic [ADDR_W-1:0] r_load_cnt;
    logic              r_gray_ready;
    logic              r_done;
    logic [14:0]       r_wr_count;

    logic              w_load_we;
    logic              w_wr_en;
    logic              w_enter_ready;
    logic [7:0]        w_gray_rd;
    logic [7:0]        w_gray_rr;
    logic [7:0]        w_res_ar;

    assign w_load_we     = load_valid && (r_state == ST_LOAD);
    assign w_enter_ready = w_load_we && (r_load_cnt == c_last_addr);
    assign w_wr_en       = lbp_valid && ((r_state == ST_READY) || (r_state == ST_RUN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_load_cnt   <= '0;
            r_gray_ready <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_we) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                        if (w_enter_ready) begin
                            r_state      <= ST_READY;
                            r_gray_ready <= 1'b1;
                        end
                    end
                end
                ST_READY, ST_RUN: begin
                    if (finish) begin
                        r_state      <= ST_DONE;
                        r_gray_ready <= 1'b0;
                        r_done       <= 1'b1;
                    end else if (r_state == ST_READY && gray_req) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_wr_en && (r_wr_count != c_wr_max)) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

`ifdef LBP_HOST_DUPCHK_EN
    logic [MEM_DEPTH-1:0] r_wr_map;
    logic                 r_dup_err;

    always_ff @(posedge clk) begin
        if (w_enter_ready) begin
            r_wr_map <= '0;
        end else if (w_wr_en) begin
            r_wr_map[lbp_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dup_err <= 1'b0;
        end else if (w_wr_en && r_wr_map[lbp_addr]) begin
            r_dup_err <= 1'b1;
        end
    end

    assign dup_err = r_dup_err;
`else
    assign dup_err = 1'b0;
`endif

    lbp_img_ram #(.DEPTH(MEM_DEPTH), .WIDTH(8), .AW(ADDR_W)) u_gray_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (w_load_we),
        .waddr  (r_load_cnt),
        .wdata  (load_data),
        .araddr (gray_addr),
        .ardata (w_gray_rd),
        .rraddr ('0),
        .rrdata (w_gray_rr)
    );

    lbp_img_ram #(.DEPTH(MEM_DEPTH), .WIDTH(8), .AW(ADDR_W)) u_res_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (w_wr_en),
        .waddr  (lbp_addr),
        .wdata  (lbp_data),
        .araddr ('0),
        .ardata (w_res_ar),
        .rraddr (rd_addr),
        .rrdata (rd_data)
    );

    // Spare RAM ports are intentionally left without a consumer.
    logic w_unused_ports;
    assign w_unused_ports = ^{w_gray_rr, w_res_ar};

    assign gray_ready = r_gray_ready;
    assign gray_data  = (gray_req && r_gray_ready) ? w_gray_rd : 8'h00;
    assign done       = r_done;
    assign wr_count   = r_wr_count;

endmodule

`default_nettype wire
